// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the streaming FIFO and anything else that needs a
// circular buffer whose depth is not a power of two.
//   FIFO_DEFAULT_DEPTH : default entry count used by stream_fifo
//   FIFO_COUNT_W       : occupancy-counter width for the default depth
//   count_width()      : occupancy-counter width for an arbitrary depth
//   ptr_inc()          : advance a pointer by one, wrapping at depth-1 -> 0
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEFAULT_DEPTH = 3072;

  // The counter must be able to hold the value DEPTH itself (completely full),
  // hence depth+1 rather than depth.
  function automatic int count_width(input int depth);
    count_width = $clog2(depth + 1);
  endfunction

  localparam int FIFO_COUNT_W = count_width(FIFO_DEFAULT_DEPTH);

  // Wrap explicitly at depth-1, so a non-power-of-two depth never walks
  // into unused addresses.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    if (ptr >= depth - 1)
      ptr_inc = 0;
    else
      ptr_inc = ptr + 1;
  endfunction

endpackage

// File: rtl/RAM_param.sv
// ---------------------------------------------------------------------------
// RAM_param
// Simple dual-port RAM: one synchronous write port and one synchronous read
// port with a registered output. There is no reset on the array or the read
// register, so it maps onto block RAM.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address, sampled on the rising edge
//   o_rdata : registered read data (returns the old contents when the same
//             address is read and written at one edge)
// ---------------------------------------------------------------------------
module RAM_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3072,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and read share one block, so a read of the location being written
  // returns the previous contents. The FIFO control relies on this: it never
  // presents a word on the edge that writes it.
  always_ff @(posedge i_clk) begin
    if (i_we)
      mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
// Valid/ready streaming FIFO built on a registered-output RAM. The depth does
// not have to be a power of two. The write-to-read latency is two edges. There
// is no bypass, so o_data always comes straight from the RAM read register.
//   i_clk         : clock, rising edge
//   i_rst         : asynchronous active-high reset
//   i_valid/i_data: upstream word offered
//   o_ready       : a word can be accepted this cycle (not full)
//   o_valid/o_data: head word presented downstream
//   i_ready       : downstream accepts the head word
//   o_count       : number of stored words
//   o_almost_full : o_count >= AFULL_LEVEL (registered)
// ---------------------------------------------------------------------------
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = FIFO_DEFAULT_DEPTH,
  parameter int AFULL_LEVEL = DEPTH - 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_inc;
  logic [PW-1:0] rd_ptr_inc;
  logic [PW-1:0] rd_addr;
  logic [CW-1:0] count_next;
  logic          valid_next;
  logic          afull_next;

  assign o_ready = (o_count != CW'(DEPTH));

  // Reset masks the push so that nothing lands in the RAM while the pointers
  // are held at zero. A pop cannot happen during reset because o_valid is
  // forced low.
  assign push = i_valid && o_ready && !i_rst;
  assign pop  = o_valid && i_ready;

  assign wr_ptr_inc = PW'(ptr_inc(32'(wr_ptr), DEPTH));
  assign rd_ptr_inc = PW'(ptr_inc(32'(rd_ptr), DEPTH));

  // Reading ahead (head+1) on a pop edge puts the next word in the RAM
  // output register on the same edge that the current one leaves, so a
  // run of pops has no bubble.
  assign rd_addr = pop ? rd_ptr_inc : rd_ptr;

  // The next count drives the registered almost-full flag. valid_next uses the
  // pre-edge count, so a word written on this edge (not yet readable through
  // the RAM register) is never counted as presentable.
  always_comb begin
    count_next = o_count;
    if (push && !pop)
      count_next = o_count + CW'(1);
    else if (pop && !push)
      count_next = o_count - CW'(1);
    valid_next = ((o_count - CW'(pop)) != '0);
    afull_next = (count_next >= CW'(AFULL_LEVEL));
  end

  // Control state: pointers, occupancy, and both registered flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_count       <= '0;
      o_valid       <= 1'b0;
      o_almost_full <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr_inc;
      if (pop)
        rd_ptr <= rd_ptr_inc;
      o_count       <= count_next;
      o_valid       <= valid_next;
      o_almost_full <= afull_next;
    end
  end

  RAM_param #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (PW)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (push),
    .i_waddr(wr_ptr),
    .i_wdata(i_data),
    .i_raddr(rd_addr),
    .o_rdata(o_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
// Directed self-checking bench for stream_fifo at its default parameters
// (8-bit words, depth 3072, almost-full at 3068).
// ---------------------------------------------------------------------------
module tb_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 3072;
  localparam int AFULL = DEPTH - 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          i_clk;
  logic          i_rst;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic [CW-1:0] o_count;
  logic          o_almost_full;

  int checkCount = 0;
  int errorCount = 0;

  stream_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_almost_full(o_almost_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                               input logic ready);
    i_valid = valid;
    i_data  = data;
    i_ready = ready;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    tick();
    checkOutput("rst_count", 32'(o_count), 32'd0);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_afull", 32'(o_almost_full), 32'd0);
    i_rst = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(o_ready), 32'd1);

    // Single word: two-edge latency, then held while the downstream stalls.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lat_valid_e1", 32'(o_valid), 32'd0);
    checkOutput("lat_count_e1", 32'(o_count), 32'd1);
    tick();
    checkOutput("lat_valid_e2", 32'(o_valid), 32'd1);
    checkOutput("lat_data_e2", 32'(o_data), 32'hA5);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("hold_valid", 32'(o_valid), 32'd1);
      checkOutput("hold_data", 32'(o_data), 32'hA5);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("pop1_valid", 32'(o_valid), 32'd0);
    checkOutput("pop1_count", 32'(o_count), 32'd0);

    // Fill to capacity with the downstream stalled.
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("fill_ready", 32'(o_ready), 32'd1);
      applyStimulus(1'b1, 8'(i), 1'b0);
      tick();
      checkOutput("fill_count", 32'(o_count), 32'(i + 1));
      checkOutput("fill_afull", 32'(o_almost_full), 32'((i + 1) >= AFULL));
    end
    checkOutput("full_ready", 32'(o_ready), 32'd0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    tick();
    tick();
    checkOutput("full_ignore_count", 32'(o_count), 32'(DEPTH));
    checkOutput("full_ignore_ready", 32'(o_ready), 32'd0);
    checkOutput("full_head", 32'(o_data), 32'h00);

    // Drain with the downstream always ready: one word per cycle, in order.
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain_valid", 32'(o_valid), 32'd1);
      checkOutput("drain_data", 32'(o_data), 32'(i & 255));
      checkOutput("drain_count", 32'(o_count), 32'(DEPTH - i));
      tick();
    end
    checkOutput("drain_end_valid", 32'(o_valid), 32'd0);
    checkOutput("drain_end_count", 32'(o_count), 32'd0);
    checkOutput("drain_end_afull", 32'(o_almost_full), 32'd0);
    checkOutput("drain_end_ready", 32'(o_ready), 32'd1);

    // Continuous streaming long enough to wrap both pointers several times.
    for (int n = 0; n < 10000; n++) begin
      checkOutput("stream_valid", 32'(o_valid), 32'(n >= 2));
      checkOutput("stream_count", 32'(o_count), (n >= 2) ? 32'd2 : 32'(n));
      if (n >= 2)
        checkOutput("stream_data", 32'(o_data), 32'((n - 2) & 255));
      applyStimulus(1'b1, 8'(n), 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stream_tail0", 32'(o_data), 32'(9998 & 255));
    tick();
    checkOutput("stream_tail1_valid", 32'(o_valid), 32'd1);
    checkOutput("stream_tail1", 32'(o_data), 32'(9999 & 255));
    tick();
    checkOutput("stream_end_valid", 32'(o_valid), 32'd0);
    checkOutput("stream_end_count", 32'(o_count), 32'd0);

    // Push and pop together at count 1: one bubble, then the new word.
    applyStimulus(1'b1, 8'h11, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("pp_head", 32'(o_data), 32'h11);
    checkOutput("pp_head_valid", 32'(o_valid), 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pp_bubble_valid", 32'(o_valid), 32'd0);
    checkOutput("pp_bubble_count", 32'(o_count), 32'd1);
    tick();
    checkOutput("pp_new_valid", 32'(o_valid), 32'd1);
    checkOutput("pp_new_data", 32'(o_data), 32'h22);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("pp_end_valid", 32'(o_valid), 32'd0);
    checkOutput("pp_end_count", 32'(o_count), 32'd0);

    // Asynchronous reset with 500 words stored.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'b1, 8'(i + 3), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("pre_rst_count", 32'(o_count), 32'd500);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(o_valid), 32'd0);
    checkOutput("arst_count", 32'(o_count), 32'd0);
    // A word offered during reset must not be stored.
    applyStimulus(1'b1, 8'h77, 1'b1);
    tick();
    checkOutput("arst_edge_count", 32'(o_count), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    i_rst = 1'b0;
    #1;
    applyStimulus(1'b1, 8'h5A, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("post_rst_valid", 32'(o_valid), 32'd1);
    checkOutput("post_rst_data", 32'(o_data), 32'h5A);
    checkOutput("post_rst_count", 32'(o_count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("post_rst_empty", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 3072, giving the entry count; it need not be a power of two.
REQ-003 The module SHALL have parameter AFULL_LEVEL, default DEPTH-4, giving the almost-full occupancy threshold.
REQ-004 Port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port i_rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port i_valid, input, 1: upstream word offered.
REQ-007 Port i_data, input, DATA_WIDTH: upstream word.
REQ-008 Port o_ready, output, 1: FIFO can accept a word this cycle.
REQ-009 Port o_valid, output, 1: head word presented downstream.
REQ-010 Port o_data, output, DATA_WIDTH: head word.
REQ-011 Port i_ready, input, 1: downstream accepts the head word.
REQ-012 Port o_count, output, $clog2(DEPTH+1): stored-word count.
REQ-013 Port o_almost_full, output, 1: o_count >= AFULL_LEVEL.

Function
REQ-014 Push SHALL occur at an edge where i_valid && o_ready; pop SHALL occur at an edge where o_valid && i_ready.
REQ-015 o_ready SHALL be combinational, equal to (o_count != DEPTH); i_valid while full SHALL be ignored, with no state change.
REQ-016 Write pointer and read pointer SHALL each wrap from DEPTH-1 to 0, not at a power-of-two boundary.
REQ-017 o_count SHALL increment on push-only, decrement on pop-only, and be unchanged on simultaneous push and pop.
REQ-018 RAM read address SHALL be combinational: head+1 (wrapped) at a pop edge, else head, so back-to-back pops run at one word per cycle with no bubble.
REQ-019 o_data SHALL be the RAM's registered read output, never muxed with i_data (no bypass path).
REQ-020 o_valid SHALL be registered: next value = ((o_count - pop) != 0), using the pre-edge o_count, so a word written at edge k is excluded.
REQ-021 Write to empty FIFO at edge k SHALL give o_valid=1 with that word on o_data after edge k+1 (two-edge fall-through latency).
REQ-022 While o_valid && !i_ready, o_data and o_valid SHALL hold stable; the head entry SHALL never be overwritten (guaranteed by REQ-015).
REQ-023 Simultaneous push and pop at o_count==DEPTH cannot occur (o_ready=0); at o_count==1 the popped head SHALL be replaced by a presentation of the new word one edge later, with o_valid=0 in between.
REQ-024 o_almost_full SHALL be registered and consistent with o_count after every edge.

Reset
REQ-025 While i_rst=1, pointers=0, o_count=0, o_valid=0, o_almost_full=0, and o_ready=1 after release.
REQ-026 Reset mid-operation SHALL discard all stored words; RAM contents are not cleared and o_data is don't-care while o_valid=0.
REQ-027 No push or pop SHALL be recognised at any edge where i_rst=1.

Structure
REQ-028 Storage SHALL be one instance of RAM_param (DATA_WIDTH, DEPTH passed through), write enable = push; it is the only sub-module.
REQ-029 Pointer-increment-with-wrap function and the count-width constant SHALL live in shared package fifo_pkg.
REQ-030 Control (pointers, count, flags) SHALL be in stream_fifo itself, with no further hierarchy.

Verification
REQ-031 Reset, then push 0xA5 at edge 1 with i_ready=0 -> o_valid=0 after edge 1, o_valid=1 and o_data=0xA5 after edge 2, held while i_ready=0.
REQ-032 Push 3072 words 0..3071 (mod 256), i_ready=0 -> o_ready=0 at o_count=3072, o_almost_full from count 3068, and extra i_valid ignored.
REQ-033 From full, drain with i_ready=1 constant -> one word per cycle in order 0x00,0x01,..., no bubble, o_valid=0 after last.
REQ-034 Stream 10000 words with i_valid=i_ready=1 -> pointers wrap at 3071->0 repeatedly, o_count steady, data in order.
REQ-035 Push/pop simultaneously at o_count=1 (head 0x11, new 0x22) -> 0x11 accepted, o_valid=0 one cycle, then 0x22 presented.
REQ-036 Assert i_rst asynchronously mid-stream at o_count=500 -> o_valid=0, o_count=0 immediately, and next pushed word 0x5A is the first popped.
